light_sequencer: RTL and testbench
==================================

Name: light_sequencer

Overview:
- Read-side master for the traffic-light datapath register file.
- Walks phases 0..reg_num-1 in order. For each phase it issues a read-enable and read address, and captures the returned 3-bit duration.
- Counts the duration down on an external TICK strobe, drives the lamp outputs, then advances to the next phase.
- Sits between the register file read port A and the lamp drivers.

Parameters:
data_width, 3, width of the duration word returned by the register file
reg_width, 2, width of the register/phase address
reg_num, 4, number of phases; phase index wraps after reg_num-1

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous active-high reset
EN  input  1  run enable; low forces IDLE
TICK  input  1  single-cycle time-base strobe; counting happens only on cycles with TICK=1
RD_DATA  input  data_width  duration from register file outA; valid the cycle after REA=1
REA  output  1  read enable to register file port A
RAA  output  reg_width  read address to register file port A
PHASE  output  reg_width  current phase index
LIGHT  output  3  lamp drive {R,Y,G}
PHASE_DONE  output  1  one-cycle pulse on the last counted TICK of a phase

Behaviour:
- Reset (synchronous, RST=1 at a rising edge):
  - state=IDLE, PHASE=0, counter=0.
  - REA=0, RAA=0, PHASE_DONE=0, LIGHT=3'b100.
  - RST has priority over every other input in every state.
- States: IDLE, FETCH, LOAD, RUN. REA, RAA and LIGHT are decoded from the state and PHASE registers only (Moore outputs).
- IDLE:
  - LIGHT=3'b100 (safe red), REA=0.
  - EN=1 -> FETCH on the next edge; PHASE is held, not reset.
- FETCH (exactly 1 cycle):
  - REA=1, RAA=PHASE.
  - Always -> LOAD.
- LOAD (exactly 1 cycle):
  - REA=0. RD_DATA is valid in this cycle.
  - counter <= (RD_DATA==0) ? 1 : RD_DATA. A zero duration is treated as 1.
  - -> RUN.
- RUN:
  - TICK=1 and counter>1: counter decrements.
  - TICK=1 and counter==1:
    - PHASE_DONE=1 for that cycle, combinational from state/counter/TICK.
    - PHASE <= (PHASE==reg_num-1) ? 0 : PHASE+1.
    - -> FETCH.
  - TICK=0: counter holds.
- LIGHT in FETCH, LOAD and RUN depends on PHASE:
  - PHASE=0 -> 3'b001 (G)
  - PHASE=1 -> 3'b010 (Y)
  - any other PHASE -> 3'b100 (R)
  - FETCH and LOAD show the lamps of the new PHASE, with no glitch to IDLE red between phases.
- Latency: with TICK held high, each phase occupies 2+d' cycles, where d'=max(RD_DATA,1). These are FETCH, LOAD, then d' RUN cycles.
- EN=0 in any non-IDLE state:
  - -> IDLE on the next edge. PHASE is held, counter is discarded, PHASE_DONE=0.
  - On EN=1 again, re-fetch the same PHASE with a full fresh duration.
- EN=0 and TICK=1 on the final RUN count in the same cycle: EN wins. No PHASE_DONE, no phase advance.
- A TICK during FETCH or LOAD is ignored and does not count.
- The counter is data_width bits wide; maximum duration is 2^data_width-1 ticks. No overflow is possible because the counter only decrements from a loaded value ≥1.
- RST asserted mid-RUN: next cycle matches the reset values above, including PHASE=0.

Test Plan:
- Reset sequence: RST=1 for 2 cycles, then EN=0 -> LIGHT=3'b100, PHASE=0, REA=0, RAA=0, PHASE_DONE=0, and the state stays IDLE indefinitely.
- Full cycle: regfile preloaded {0:3,1:1,2:2,3:4}, TICK=1 constantly, EN=1 -> phase lengths of 5, 3, 4 and 6 cycles.
  - REA pulses with RAA=0,1,2,3,0.
  - LIGHT goes 001, 010, 100, 100.
  - PHASE_DONE fires 4 times, then PHASE wraps to 0.
- Zero duration: regfile entry 1=0 -> phase 1 lasts exactly 3 cycles, with one PHASE_DONE.
- Sparse TICK: TICK every 4th cycle, entry 0=2 -> PHASE stays 0 until the 2nd TICK in RUN. PHASE_DONE coincides with that TICK. A TICK landing in FETCH or LOAD is not counted.
- Enable drop: EN=0 during RUN of phase 2 with counter=1 and TICK=1 in the same cycle -> IDLE, PHASE stays 2, no PHASE_DONE, LIGHT=100. On EN=1, RAA=2 is re-fetched and the full duration runs again.
- Reset mid-RUN: RST=1 in phase 3, RUN, counter=3 -> next cycle PHASE=0, LIGHT=100, REA=0, state IDLE.

Source files
------------

// File: rtl/light_sequencer.sv
// Traffic-light phase sequencer: fetches each phase duration from register
// file port A, counts it down on TICK and drives the lamps for that phase.
module light_sequencer #(
  parameter int data_width = 3,
  parameter int reg_width  = 2,
  parameter int reg_num    = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  TICK,
  input  logic [data_width-1:0] RD_DATA,
  output logic                  REA,
  output logic [reg_width-1:0]  RAA,
  output logic [reg_width-1:0]  PHASE,
  output logic [2:0]            LIGHT,
  output logic                  PHASE_DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [reg_width-1:0]  phase_q, phase_d;
  logic [data_width-1:0] cnt_q,   cnt_d;
  logic                  last_tick;

  function automatic logic [2:0] lamp(input logic [reg_width-1:0] p);
    if (p == '0)                   return 3'b001;
    else if (p == reg_width'(1))   return 3'b010;
    else                           return 3'b100;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // EN low beats the final count, so no completion is reported when dropping out.
  assign last_tick = (state_q == RUN) && TICK && (cnt_q == data_width'(1)) && EN && !RST;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (EN) state_d = FETCH;
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = (RD_DATA == '0) ? data_width'(1) : RD_DATA;
        state_d = RUN;
      end
      RUN: begin
        if (TICK) begin
          if (cnt_q == data_width'(1)) begin
            phase_d = (phase_q == reg_width'(reg_num - 1)) ? '0 : phase_q + reg_width'(1);
            state_d = FETCH;
          end else begin
            cnt_d = cnt_q - data_width'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!EN) begin
      state_d = IDLE;
      phase_d = phase_q;
      cnt_d   = '0;
    end
  end

  assign REA        = (state_q == FETCH);
  assign RAA        = (state_q == FETCH) ? phase_q : '0;
  assign PHASE      = phase_q;
  assign LIGHT      = (state_q == IDLE) ? 3'b100 : lamp(phase_q);
  assign PHASE_DONE = last_tick;

endmodule

// File: tb/tb_light_sequencer.sv
// Scoreboard bench for light_sequencer: a phase/age reference model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_light_sequencer;

  logic       CLK = 1'b0;
  logic       RST, EN, TICK;
  logic [2:0] RD_DATA;
  logic       REA;
  logic [1:0] RAA, PHASE;
  logic [2:0] LIGHT;
  logic       PHASE_DONE;

  light_sequencer #(.data_width(3), .reg_width(2), .reg_num(4)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .TICK(TICK), .RD_DATA(RD_DATA),
    .REA(REA), .RAA(RAA), .PHASE(PHASE), .LIGHT(LIGHT), .PHASE_DONE(PHASE_DONE)
  );

  always #5 CLK = ~CLK;

  // Register file read port A: registered, data valid the cycle after REA.
  logic [2:0] mem [4];
  always @(posedge CLK) if (REA) RD_DATA <= mem[RAA];

  typedef struct packed {
    logic       rea;
    logic [1:0] raa;
    logic [1:0] phase;
    logic [2:0] light;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   started = 1'b0;

  // Reference model: running flag, cycles since the phase fetch, ticks left.
  bit   m_active;
  int   m_phase, m_age, m_left;
  logic [2:0] lamp_tab [4];

  function automatic void chk(string nm, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endfunction

  always @(negedge CLK) begin
    if (started) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("REA",        int'(REA),        int'(e.rea));
        chk("RAA",        int'(RAA),        int'(e.raa));
        chk("PHASE",      int'(PHASE),      int'(e.phase));
        chk("LIGHT",      int'(LIGHT),      int'(e.light));
        chk("PHASE_DONE", int'(PHASE_DONE), int'(e.done));
      end
    end
  end

  task automatic model_reset();
    m_active = 1'b0; m_phase = 0; m_age = 0; m_left = 0;
  endtask

  // Apply one cycle of inputs, predict this cycle's outputs, then advance the model.
  task automatic cyc(input logic rst, input logic en, input logic tick);
    exp_t e;
    bit   fetching, finishing;
    RST = rst; EN = en; TICK = tick;
    fetching  = m_active && (m_age == 0);
    finishing = m_active && (m_age >= 2) && tick && (m_left == 1) && en && !rst;
    e.rea   = fetching;
    e.raa   = fetching ? 2'(m_phase) : 2'd0;
    e.phase = 2'(m_phase);
    e.light = m_active ? lamp_tab[m_phase] : 3'b100;
    e.done  = finishing;
    exp_q.push_back(e);
    if (rst) model_reset();
    else if (!en) m_active = 1'b0;
    else if (!m_active) begin m_active = 1'b1; m_age = 0; end
    else if (m_age == 0) m_age = 1;
    else if (m_age == 1) begin m_left = (mem[m_phase] == 0) ? 1 : int'(mem[m_phase]); m_age = 2; end
    else if (tick) begin
      if (m_left == 1) begin m_phase = (m_phase + 1) % 4; m_age = 0; end
      else m_left--;
    end
    @(posedge CLK); #1;
  endtask

  task automatic timeout(input string nm);
    total++; bad++;
    $display("FAIL %s: condition not reached within bound, got timeout expected event", nm);
  endtask

  initial begin
    int n;
    lamp_tab[0] = 3'b001; lamp_tab[1] = 3'b010; lamp_tab[2] = 3'b100; lamp_tab[3] = 3'b100;
    mem[0] = 3; mem[1] = 1; mem[2] = 2; mem[3] = 4;
    RST = 1'b1; EN = 1'b0; TICK = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    model_reset();
    started = 1'b1;

    // Reset then EN low: parked in safe red.
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1);

    // Full cycle through all phases with TICK always high.
    for (int i = 0; i < 22; i++) cyc(1'b0, 1'b1, 1'b1);

    // Zero duration in phase 1.
    cyc(1'b1, 1'b0, 1'b0);
    mem[1] = 0;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b1);

    // Sparse TICK, every 4th cycle, phase 0 length 2.
    cyc(1'b1, 1'b0, 1'b0);
    mem[0] = 2; mem[1] = 1;
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, (i % 4) == 3);

    // Enable drop on the final count of phase 2, then re-fetch.
    cyc(1'b1, 1'b0, 1'b0);
    mem[0] = 3; mem[2] = 2;
    n = 0;
    while (!(m_active && m_phase == 2 && m_age >= 2 && m_left == 1) && n < 60) begin
      cyc(1'b0, 1'b1, 1'b1); n++;
    end
    if (n >= 60) timeout("enable_drop_setup");
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b1);

    // Reset in phase 3 while three ticks remain.
    n = 0;
    while (!(m_active && m_phase == 3 && m_age >= 2 && m_left == 3) && n < 60) begin
      cyc(1'b0, 1'b1, 1'b1); n++;
    end
    if (n >= 60) timeout("reset_mid_run_setup");
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);

    // Randomized segments with fresh register file contents.
    for (int s = 0; s < 20; s++) begin
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 4; k++) mem[k] = 3'($urandom_range(0, 7));
      for (int i = 0; i < 80; i++)
        cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) != 0), ($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
